// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and default widths for the two-client RAM arbiter
// Contents:
//   DEF_DATA_W / DEF_ADDR_W / DEF_DEPTH  default RAM word width, address width, implemented words
//   state_t                              sequencer states IDLE, ISSUE, WAIT, DONE
//   req_t                                one client transaction {we, addr, wdata}
package ram_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rtl/ram_arbiter_rr_arb2.sv - combinational two-way round-robin picker
// Ports:
//   i_req[1:0]  request from client 1 / client 0
//   i_last      client that owned the previous transaction
//   o_grant_id  selected client (meaningful only when o_any is high)
//   o_any       at least one client is requesting
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant_id,
    output logic       o_any
);

    assign o_any = |i_req;

    // On contention the client that did not go last wins; otherwise the lone requester.
    assign o_grant_id = (&i_req) ? ~i_last : i_req[1];

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-client round-robin sequencer in front of a synchronous RAM
// Optional feature macro: RAM_ARB_ADDR_CHECK_EN (address range check, adds o_addr_err)
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), asynchronous active-low reset
//   i_req0/1, i_we0/1              client request (held until done), 1 = write / 0 = read
//   i_addr0/1, i_wdata0/1          client address and write data
//   o_gnt0/1                       client owns the RAM (ISSUE..DONE)
//   o_done0/1                      one-cycle completion pulse
//   o_rdata                        last completed read result
//   o_ram_we, o_ram_re             RAM enables, high only in ISSUE
//   o_ram_addr, o_ram_wdata        latched address / write data toward the RAM
//   i_ram_rdata                    RAM registered read data (one cycle after o_ram_re)
//   o_addr_err                     (RAM_ARB_ADDR_CHECK_EN only) pulse in DONE for an out-of-range access
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_done0,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ram_we,
    output logic              o_ram_re,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
`ifdef RAM_ARB_ADDR_CHECK_EN
    output logic              o_addr_err,
`endif
    input  logic [DATA_W-1:0] i_ram_rdata
);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_any;
    logic              w_gid;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_skip;

    rr_arb2 u_rr (
        .i_req      ({i_req1, i_req0}),
        .i_last     (r_last),
        .o_grant_id (w_gid),
        .o_any      (w_any)
    );

    assign w_sel_we    = w_gid ? i_we1    : i_we0;
    assign w_sel_addr  = w_gid ? i_addr1  : i_addr0;
    assign w_sel_wdata = w_gid ? i_wdata1 : i_wdata0;

`ifdef RAM_ARB_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] W_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic r_err;
    logic w_sel_bad;

    // Extra leading zero keeps the compare correct when DEPTH equals 2**ADDR_W.
    assign w_sel_bad = ({1'b0, w_sel_addr} >= W_DEPTH);
    assign w_skip    = r_err;
`else
    assign w_skip    = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        o_gnt0   = 1'b0;
        o_gnt1   = 1'b0;
        o_done0  = 1'b0;
        o_done1  = 1'b0;
        o_ram_we = 1'b0;
        o_ram_re = 1'b0;
`ifdef RAM_ARB_ADDR_CHECK_EN
        o_addr_err = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                o_ram_we = r_we & ~w_skip;
                o_ram_re = ~r_we & ~w_skip;
                // A suppressed access has no read data to wait for.
                w_next   = (r_we | w_skip) ? DONE : WAIT;
            end
            WAIT: begin
                w_next = DONE;
            end
            DONE: begin
                o_done0 = ~r_owner;
                o_done1 = r_owner;
`ifdef RAM_ARB_ADDR_CHECK_EN
                o_addr_err = r_err;
`endif
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (r_state != IDLE) begin
            o_gnt0 = ~r_owner;
            o_gnt1 = r_owner;
        end
    end

    // Transaction fields are copied at grant so clients may change them once granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
`ifdef RAM_ARB_ADDR_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE && w_any) begin
                r_owner <= w_gid;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
`ifdef RAM_ARB_ADDR_CHECK_EN
                r_err   <= w_sel_bad;
`endif
            end
            if (r_state == WAIT) begin
                r_rdata <= i_ram_rdata;
            end
            if (r_state == DONE) begin
                r_last <= r_owner;
            end
        end
    end

    assign o_rdata     = r_rdata;
    assign o_ram_addr  = r_addr;
    assign o_ram_wdata = r_wdata;

endmodule
